// File: rtl/status_led_pkg.sv
// Shared types for the status LED controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package status_led_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_ERR
    } ch_state_t;

    localparam int MAX_CH = 8;

endpackage

// File: rtl/status_led_ch.sv
// One status channel: idle/busy/sticky-error FSM plus activity stretch counter.
// Latency: state and counter update on the edge that samples the inputs.
// Backpressure: none; inputs are levels/strobes and are never stalled.
module status_led_ch
    import status_led_pkg::*;
#(
    parameter int STRETCH_TICKS = 50
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      idle,
    input  logic      err,
    input  logic      clr,
    input  logic      act,
    input  logic      tick,
    output ch_state_t state,
    output logic      act_on
);

    // Counter must hold the load value itself, hence +1.
    localparam int SW = (STRETCH_TICKS > 0) ? $clog2(STRETCH_TICKS + 1) : 1;
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_TICKS);

    ch_state_t     state_d;
    logic [SW-1:0] stretch_cnt;

    always_comb begin
        state_d = idle ? S_IDLE : S_BUSY;
        if (err) begin
            state_d = S_ERR;
        end else if ((state == S_ERR) && !clr) begin
            state_d = S_ERR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            stretch_cnt <= '0;
        end else begin
            state <= state_d;
            if (act) begin
                stretch_cnt <= STRETCH_LOAD;
            end else if (tick && (stretch_cnt != '0)) begin
                stretch_cnt <= stretch_cnt - SW'(1);
            end
        end
    end

    assign act_on = (stretch_cnt != '0);

endmodule

// File: rtl/status_led_ctrl.sv
// Multi-channel status LED driver: idle/busy/error indication, blink and activity stretch.
// Latency: input sampled at edge k reaches the pins at edge k+1 (FSM at k, pin register at k+1).
// Backpressure: none; free-running outputs.
module status_led_ctrl
    import status_led_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int TICK_CYC      = 50000,
    parameter int BLINK_TICKS   = 250,
    parameter int STRETCH_TICKS = 50,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic            avm_clk,
    input  logic            avm_rst,
    input  logic [N_CH-1:0] i_idle,
    input  logic [N_CH-1:0] i_err,
    input  logic [N_CH-1:0] i_clr,
    input  logic [N_CH-1:0] i_act,
    input  logic            i_lamp_test,
    output logic [N_CH-1:0] o_ledg,
    output logic [N_CH-1:0] o_ledr,
    output logic [N_CH-1:0] o_lact,
    output logic            o_err_any
);

    localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_CYC - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [BW-1:0]   blink_cnt;
    logic            blink_phase;

    ch_state_t       ch_state [N_CH];
    logic [N_CH-1:0] act_on;

    logic [N_CH-1:0] ledg_d, ledr_d, lact_d;
    logic            err_any_d;
    logic [N_CH-1:0] ledg_q, ledr_q, lact_q;
    logic            err_any_q;

    assign tick = (tick_cnt == TICK_MAX);

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            tick_cnt    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (tick) begin
                if (blink_cnt == BLINK_MAX) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        status_led_ch #(
            .STRETCH_TICKS (STRETCH_TICKS)
        ) u_ch (
            .clk    (avm_clk),
            .rst    (avm_rst),
            .idle   (i_idle[c]),
            .err    (i_err[c]),
            .clr    (i_clr[c]),
            .act    (i_act[c]),
            .tick   (tick),
            .state  (ch_state[c]),
            .act_on (act_on[c])
        );
    end

    // Lamp test overrides the LEDs but not the error summary, which may feed logic.
    always_comb begin
        ledg_d    = '0;
        ledr_d    = '0;
        err_any_d = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            ledg_d[c] = (ch_state[c] == S_IDLE);
            ledr_d[c] = (ch_state[c] == S_BUSY) | ((ch_state[c] == S_ERR) & blink_phase);
            err_any_d = err_any_d | (ch_state[c] == S_ERR);
        end
        lact_d = act_on;
        if (i_lamp_test) begin
            ledg_d = '1;
            ledr_d = '1;
            lact_d = '1;
        end
    end

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            ledg_q    <= '0;
            ledr_q    <= '0;
            lact_q    <= '0;
            err_any_q <= 1'b0;
        end else begin
            ledg_q    <= ledg_d;
            ledr_q    <= ledr_d;
            lact_q    <= lact_d;
            err_any_q <= err_any_d;
        end
    end

    assign o_ledg    = ledg_q ^ {N_CH{ACTIVE_LOW}};
    assign o_ledr    = ledr_q ^ {N_CH{ACTIVE_LOW}};
    assign o_lact    = lact_q ^ {N_CH{ACTIVE_LOW}};
    assign o_err_any = err_any_q ^ ACTIVE_LOW;

endmodule

// File: tb/tb_status_led_ctrl.sv
// Bench for status_led_ctrl: directed scenarios plus randomized traffic against an arithmetic model.
// Latency: n/a. Backpressure: n/a.
module tb_status_led_ctrl;

    localparam int TC = 4;
    localparam int BT = 2;
    localparam int ST = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] idle, err, clr, act;
    logic       lamp;

    logic [1:0] ledg, ledr, lact;
    logic       err_any;
    logic [1:0] ledg_n, ledr_n, lact_n;
    logic       err_any_n;

    always #5 clk = ~clk;

    status_led_ctrl #(
        .N_CH(2), .TICK_CYC(TC), .BLINK_TICKS(BT), .STRETCH_TICKS(ST), .ACTIVE_LOW(1'b0)
    ) dut (
        .avm_clk(clk), .avm_rst(rst), .i_idle(idle), .i_err(err), .i_clr(clr), .i_act(act),
        .i_lamp_test(lamp), .o_ledg(ledg), .o_ledr(ledr), .o_lact(lact), .o_err_any(err_any)
    );

    status_led_ctrl #(
        .N_CH(2), .TICK_CYC(TC), .BLINK_TICKS(BT), .STRETCH_TICKS(ST), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .avm_clk(clk), .avm_rst(rst), .i_idle(idle), .i_err(err), .i_clr(clr), .i_act(act),
        .i_lamp_test(lamp), .o_ledg(ledg_n), .o_ledr(ledr_n), .o_lact(lact_n), .o_err_any(err_any_n)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            failures++;
            $display("FAIL %s: got %0d want %0d..%0d at %0t", name, got, lo, hi, $time);
        end
    endtask

    // Model: edges since reset, per-channel error flag, last idle level, edge of last act load.
    bit         model_ok = 1'b0;
    int         e;
    bit         m_err  [2];
    bit         m_idle [2];
    int         m_load [2];
    logic [1:0] x_ledg, x_ledr, x_lact;
    logic       x_any;

    // Ticks fire on edges that are multiples of TC; the load edge's own tick is overridden.
    function automatic int stretch_left(input int c, input int ee);
        int v;
        if (m_load[c] < 0) return 0;
        v = ST - (ee / TC - m_load[c] / TC);
        return (v < 0) ? 0 : v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_ok = 1'b1;
            e        = 0;
            x_ledg   = 2'b00;
            x_ledr   = 2'b00;
            x_lact   = 2'b00;
            x_any    = 1'b0;
            for (int c = 0; c < 2; c++) begin
                m_err[c]  = 1'b0;
                m_idle[c] = 1'b1;
                m_load[c] = -1;
            end
        end else if (model_ok) begin
            x_any = 1'b0;
            for (int c = 0; c < 2; c++) begin
                x_ledg[c] = !m_err[c] && m_idle[c];
                x_ledr[c] = (!m_err[c] && !m_idle[c]) || (m_err[c] && ((e / (TC * BT)) % 2 == 1));
                x_lact[c] = stretch_left(c, e) > 0;
                x_any     = x_any | m_err[c];
            end
            if (lamp) begin
                x_ledg = 2'b11;
                x_ledr = 2'b11;
                x_lact = 2'b11;
            end
            e++;
            for (int c = 0; c < 2; c++) begin
                if (err[c]) begin
                    m_err[c] = 1'b1;
                end else if (m_err[c]) begin
                    if (clr[c]) begin
                        m_err[c]  = 1'b0;
                        m_idle[c] = idle[c];
                    end
                end else begin
                    m_idle[c] = idle[c];
                end
                if (act[c]) m_load[c] = e;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("ledg", ledg, x_ledg);
            chk("ledr", ledr, x_ledr);
            chk("lact", lact, x_lact);
            chk("err_any", {1'b0, err_any}, {1'b0, x_any});
            chk("ledg_al", ledg_n, ~x_ledg);
            chk("ledr_al", ledr_n, ~x_ledr);
            chk("lact_al", lact_n, ~x_lact);
            chk("err_any_al", {1'b0, err_any_n}, {1'b0, ~x_any});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits (bounded) for lact[0] to rise, then returns how many cycles it stayed high.
    task automatic measure_lact0(input string name, output int len);
        int waited;
        waited = 0;
        len    = 0;
        while (lact[0] !== 1'b1 && waited < 40) begin
            step(1);
            waited++;
        end
        if (waited >= 40) begin
            failures++;
            checks++;
            $display("FAIL %s: lact[0] never rose within 40 cycles", name);
        end else begin
            while (lact[0] === 1'b1 && len < 60) begin
                len++;
                step(1);
            end
        end
    endtask

    int len;
    int last_chg;
    int n_chg;
    logic prev;

    initial begin
        rst  = 1'b1;
        idle = 2'b11;
        err  = 2'b00;
        clr  = 2'b00;
        act  = 2'b00;
        lamp = 1'b0;
        step(3);
        chk("rst_ledg", ledg, 2'b00);
        chk("rst_ledr", ledr, 2'b00);
        chk("rst_err_any", {1'b0, err_any}, 2'b00);
        chk("rst_ledg_al", ledg_n, 2'b11);
        chk("rst_lact_al", lact_n, 2'b11);

        rst = 1'b0;
        step(2);
        chk("rel_ledg", ledg, 2'b11);
        chk("rel_ledr", ledr, 2'b00);

        idle = 2'b10;
        step(1);
        chk("busy_early_ledg", ledg, 2'b11);
        step(1);
        chk("busy_ledg", ledg, 2'b10);
        chk("busy_ledr", ledr, 2'b01);

        err = 2'b10;
        step(1);
        err = 2'b00;
        step(1);
        chk("err_set", {1'b0, err_any}, 2'b01);
        prev     = ledr[1];
        last_chg = -1;
        n_chg    = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (ledr[1] !== prev) begin
                if (last_chg >= 0) chk_int("blink_period", i - last_chg, 8, 8);
                last_chg = i;
                n_chg++;
                prev = ledr[1];
            end
        end
        chk_int("blink_toggles", n_chg, 4, 6);
        chk("err_sticky", {1'b0, err_any}, 2'b01);

        err = 2'b10;
        clr = 2'b10;
        step(1);
        err = 2'b00;
        clr = 2'b00;
        step(2);
        chk("err_beats_clr", {1'b0, err_any}, 2'b01);

        clr = 2'b10;
        step(1);
        clr = 2'b00;
        step(1);
        chk("clr_err_any", {1'b0, err_any}, 2'b00);
        chk("clr_ledg", ledg, 2'b10);

        act = 2'b01;
        step(1);
        act = 2'b00;
        measure_lact0("stretch_len", len);
        chk_int("stretch_len", len, 9, 12);

        act = 2'b01;
        step(1);
        act = 2'b00;
        step(7);
        act = 2'b01;
        step(1);
        act = 2'b00;
        step(6);
        chk("retrig_extend", {1'b0, lact[0]}, 2'b01);
        step(20);

        for (int i = 0; i < 8; i++) begin
            if (e % TC == TC - 1) break;
            step(1);
        end
        act = 2'b01;
        step(1);
        act = 2'b00;
        measure_lact0("load_on_tick", len);
        chk_int("load_on_tick", len, 12, 12);

        err = 2'b10;
        step(1);
        err = 2'b00;
        step(3);
        lamp = 1'b1;
        step(2);
        for (int i = 0; i < 10; i++) begin
            chk("lamp_ledg", ledg, 2'b11);
            chk("lamp_ledr", ledr, 2'b11);
            chk("lamp_lact", lact, 2'b11);
            step(1);
        end
        chk("lamp_err_any", {1'b0, err_any}, 2'b01);
        lamp = 1'b0;
        step(20);

        rst = 1'b1;
        step(1);
        chk("midrst_ledr", ledr, 2'b00);
        chk("midrst_err_any", {1'b0, err_any}, 2'b00);
        chk("midrst_ledr_al", ledr_n, 2'b11);
        chk("midrst_err_any_al", {1'b0, err_any_n}, 2'b01);
        rst = 1'b0;
        step(2);
        chk("midrst_cleared", {1'b0, err_any}, 2'b00);
        chk("midrst_ledg", ledg, 2'b10);

        for (int i = 0; i < 3000; i++) begin
            idle = 2'($urandom_range(3));
            for (int c = 0; c < 2; c++) begin
                err[c] = ($urandom_range(15) == 0);
                clr[c] = ($urandom_range(7) == 0);
                act[c] = ($urandom_range(9) == 0);
            end
            if ($urandom_range(30) == 0) lamp = ~lamp;
            rst = ($urandom_range(499) == 0);
            step(1);
        end
        rst  = 1'b0;
        lamp = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
